pipelined_cla_addsub: RTL and testbench
=======================================

PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be >= 4.
REQ-002 Parameter STAGES, default 2: pipeline depth; SHALL divide WIDTH; elaboration SHALL fail otherwise.
REQ-003 Parameter GROUP, default 4: lookahead group size in bits; SHALL divide WIDTH/STAGES; elaboration SHALL fail otherwise.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 cin  input  1  carry-in (borrow-in when sub=1).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Effective operand bb = sub ? ~b : b; effective carry ce = cin XOR sub; result = a + bb + ce, modulo 2^WIDTH.
REQ-017 sub=1, cin=0 SHALL yield a-b; sub=1, cin=1 SHALL yield a-b-1.
REQ-018 Within each GROUP, generate g=a&bb and propagate p=a^bb; group carries SHALL be computed by lookahead, with no bit-serial ripple inside a group.
REQ-019 Slice k (0..STAGES-1) covers bits [k*W/S +: W/S]; stage k computes slice k using the carry registered from stage k-1.
REQ-020 Unprocessed upper operand slices and completed lower result slices SHALL travel down the pipeline with their beat.
REQ-021 Latency SHALL be exactly STAGES cycles from the accept edge to out_valid=1 when out_ready is held high.
REQ-022 Throughput SHALL be one beat per cycle when out_ready=1.
REQ-023 A beat is accepted on an edge where in_valid=1 and in_ready=1.
REQ-024 A result is consumed on an edge where out_valid=1 and out_ready=1.
REQ-025 Pipeline advance enable adv = !out_valid | out_ready; all stages advance together when adv=1 and hold when adv=0.
REQ-026 in_ready SHALL equal adv & !rst.
REQ-027 Empty stages (bubbles) SHALL carry valid=0 and SHALL never produce out_valid=1.
REQ-028 sum, cout and ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-030 When out_valid=1, the combination of in_valid=1 and out_ready=1 on the same edge SHALL consume the result and accept the new beat without a bubble.

Reset
REQ-031 With rst=1 at an edge, all stage valid bits, sum, cout and ovf SHALL be cleared to 0.
REQ-032 Beats in flight at reset SHALL be discarded and SHALL never appear on the output.
REQ-033 No beat SHALL be accepted on an edge where rst=1.
REQ-034 The first beat after rst deasserts SHALL complete with the standard STAGES-cycle latency.

Configuration
REQ-035 Macro CLA_SATURATE_EN: when defined, the block SHALL add signed saturation.
REQ-036 With CLA_SATURATE_EN defined and ovf=1: sum SHALL be 0x7FF..F if a[W-1]=0, otherwise 0x800..0; cout and ovf SHALL be unchanged.
REQ-037 With CLA_SATURATE_EN undefined, sum SHALL wrap modulo 2^WIDTH; latency and interface SHALL be identical in both builds.

Verification (WIDTH=32, STAGES=2, GROUP=4)
REQ-038 a=0xFFFFFFFF, b=0, cin=1, sub=0 -> after 2 cycles: sum=0, cout=1, ovf=0.
REQ-039 a=0x7FFFFFFF, b=1, cin=0, sub=0 -> sum=0x80000000, ovf=1, cout=0; with CLA_SATURATE_EN: sum=0x7FFFFFFF.
REQ-040 a=5, b=7, cin=0, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=7, b=5 -> sum=2, cout=1.
REQ-041 Ten back-to-back beats with out_ready=0 for cycles 3-6 -> in_ready=0 while stalled; all ten results emitted in order with no loss or duplication; outputs stable during the stall.
REQ-042 rst pulsed for 1 cycle with 2 beats in flight -> out_valid=0 the next cycle; neither in-flight result ever appears; a beat sent right after reset emerges 2 cycles later.
REQ-043 Random operands, 10^5 beats with random in_valid/out_ready, under WIDTH 8/16/32/64 and STAGES 1/2/4 -> every result matches the reference sum, cout and ovf.

Source files
------------

// File: rtl/pipelined_cla_addsub_if.sv
// Handshake and data bundle for pipelined_cla_addsub.
// The master drives the operand beat and out_ready; the slave drives results.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// Level 0 captures the effective operands; stage k adds slice k using the
// carry registered by stage k-1, so a result appears STAGES cycles after it
// was accepted. Within a slice, bit carries come from per-group lookahead and
// group carries from a second lookahead level over the group generate/propagate.
// Optional build macro CLA_SATURATE_EN clamps the sum on signed overflow.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pipelined_cla_addsub_if.slave bus
);
    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / GROUP;
    localparam int LA = (GROUP > NG) ? GROUP : NG;

    if (WIDTH < 4) begin : g_chk_width
        $error("WIDTH must be at least 4");
    end
    if (WIDTH % STAGES != 0) begin : g_chk_stages
        $error("STAGES must divide WIDTH");
    end
    if (SW % GROUP != 0) begin : g_chk_group
        $error("GROUP must divide WIDTH/STAGES");
    end

    // Carry into position n as a flat sum of products (no ripple chain).
    function automatic logic la_carry(input logic [LA-1:0] g, input logic [LA-1:0] p,
                                      input logic c0, input int n);
        logic c;
        logic t;
        c = c0;
        for (int j = 0; j < LA; j++) if (j < n) c = c & p[j];
        for (int j = 0; j < LA; j++) begin
            if (j < n) begin
                t = g[j];
                for (int k = j + 1; k < LA; k++) if (k < n) t = t & p[k];
                c = c | t;
            end
        end
        return c;
    endfunction

    // Two-level lookahead add of one slice; returns {carry out, carry into msb, sum}.
    function automatic logic [SW+1:0] slice_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                                input logic ci);
        logic [SW-1:0] g, p, s;
        logic [SW:0]   c;
        logic [LA-1:0] gg, gp, bg, bp;
        logic [NG:0]   cg;
        g  = x & y;
        p  = x ^ y;
        gg = '0;
        gp = '0;
        for (int n = 0; n < NG; n++) begin
            bg = '0;
            bp = '0;
            bg[GROUP-1:0] = g[n*GROUP +: GROUP];
            bp[GROUP-1:0] = p[n*GROUP +: GROUP];
            gg[n] = la_carry(bg, bp, 1'b0, GROUP);
            gp[n] = &p[n*GROUP +: GROUP];
        end
        for (int n = 0; n <= NG; n++) cg[n] = la_carry(gg, gp, ci, n);
        c = '0;
        for (int n = 0; n < NG; n++) begin
            bg = '0;
            bp = '0;
            bg[GROUP-1:0] = g[n*GROUP +: GROUP];
            bp[GROUP-1:0] = p[n*GROUP +: GROUP];
            for (int i = 0; i < GROUP; i++) c[n*GROUP+i] = la_carry(bg, bp, cg[n], i);
        end
        c[SW] = cg[NG];
        s = p ^ c[SW-1:0];
        return {c[SW], c[SW-1], s};
    endfunction

`ifdef CLA_SATURATE_EN
    // Clamp to the signed extreme on the side of operand a.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] r, input logic ov,
                                                  input logic amsb);
        if (!ov) return r;
        return amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    logic             vld_p  [STAGES];
    logic [WIDTH-1:0] a_p    [STAGES];
    logic [WIDTH-1:0] bb_p   [STAGES];
    logic             c_p    [STAGES];
    logic [WIDTH-1:0] res_p  [STAGES];
    logic [SW+1:0]    sl_r   [STAGES];
    logic [WIDTH-1:0] res_nx [STAGES];
    logic             vld_pn;
    logic [WIDTH-1:0] sum_pn;
    logic             cout_pn;
    logic             ovf_pn;
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt;
    logic             ovf_nxt;
    logic             adv;

    assign adv           = !vld_pn | bus.out_ready;
    assign bus.in_ready  = adv & !rst;
    assign bus.out_valid = vld_pn;
    assign bus.sum       = sum_pn;
    assign bus.cout      = cout_pn;
    assign bus.ovf       = ovf_pn;

    // Each level adds its own slice and merges it into the travelling result.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sl_r[k]   = slice_add(a_p[k][k*SW +: SW], bb_p[k][k*SW +: SW], c_p[k]);
            res_nx[k] = res_p[k];
            res_nx[k][k*SW +: SW] = sl_r[k][SW-1:0];
        end
    end

    assign cout_nxt = sl_r[STAGES-1][SW+1];
    assign ovf_nxt  = sl_r[STAGES-1][SW+1] ^ sl_r[STAGES-1][SW];
`ifdef CLA_SATURATE_EN
    assign sum_nxt  = saturate(res_nx[STAGES-1], ovf_nxt, a_p[STAGES-1][WIDTH-1]);
`else
    assign sum_nxt  = res_nx[STAGES-1];
`endif

    // Valid bits: cleared on reset, shifted together whenever the pipe advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
            vld_pn <= 1'b0;
        end else if (adv) begin
            vld_p[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
            vld_pn <= vld_p[STAGES-1];
        end
    end

    // Operand/partial-result levels; bubbles move through with their valid=0.
    always_ff @(posedge clk) begin
        if (adv) begin
            // level 0: effective operands captured
            a_p[0]   <= bus.a;
            bb_p[0]  <= bus.sub ? ~bus.b : bus.b;
            c_p[0]   <= bus.cin ^ bus.sub;
            res_p[0] <= '0;
            // level k: slices below k complete, upper operand slices still pending
            for (int k = 1; k < STAGES; k++) begin
                a_p[k]   <= a_p[k-1];
                bb_p[k]  <= bb_p[k-1];
                c_p[k]   <= sl_r[k-1][SW+1];
                res_p[k] <= res_nx[k-1];
            end
        end
    end

    // Output level: holds while stalled, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_pn  <= '0;
            cout_pn <= 1'b0;
            ovf_pn  <= 1'b0;
        end else if (adv) begin
            sum_pn  <= sum_nxt;
            cout_pn <= cout_nxt;
            ovf_pn  <= ovf_nxt;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Testbench for pipelined_cla_addsub (WIDTH=32, STAGES=2, GROUP=4).
// Expected results are queued on accept and compared on consume.
module tb_pipelined_cla_addsub;
    localparam int W = 32;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_cla_addsub_if #(.WIDTH(W)) bus ();

    pipelined_cla_addsub #(.WIDTH(W), .STAGES(S), .GROUP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W+1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic         stall_prev = 1'b0;
    logic [W+1:0] held = '0;

    // Reference: {cout, ovf, sum}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        logic [W-1:0] bb;
        logic [W:0]   t;
        logic         ov;
        logic [W-1:0] r;
        bb = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c ^ s};
        ov = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
        r  = t[W-1:0];
`ifdef CLA_SATURATE_EN
        if (ov) r = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return {t[W], ov, r};
    endfunction

    task automatic check(input string tag, input logic [W+1:0] got, input logic [W+1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            check_bit("in_ready_during_rst", bus.in_ready, 1'b0);
        end else begin
            if (bus.out_valid && !bus.out_ready) begin
                check_bit("in_ready_stalled", bus.in_ready, 1'b0);
                if (stall_prev) check("stall_hold", {bus.cout, bus.ovf, bus.sum}, held);
                held       = {bus.cout, bus.ovf, bus.sum};
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_bad++;
                    $error("FAIL unexpected_out: observed %h expected no result", {bus.cout, bus.ovf, bus.sum});
                end
                if (exp_q.size() != 0) check("result", {bus.cout, bus.ovf, bus.sum}, exp_q.pop_front());
            end
        end
    end

    // One cycle of stimulus; call just after a rising edge.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input logic ordy,
                        input logic use_k, input logic [W+1:0] k, output logic acc);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = c;
        bus.sub       = s;
        bus.out_ready = ordy;
        @(negedge clk);
        acc = v && bus.in_ready;
        if (acc) exp_q.push_back(use_k ? k : model(a, b, c, s));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_bad++;
            $error("FAIL drain: observed %0d outstanding expected 0", exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic         acc;
        int           cyc;
        int           sent;
        logic [W+1:0] k039;
        logic [W+1:0] k_ovn;

`ifdef CLA_SATURATE_EN
        k039  = {1'b0, 1'b1, 32'h7FFFFFFF};
        k_ovn = {1'b1, 1'b1, 32'h80000000};
`else
        k039  = {1'b0, 1'b1, 32'h80000000};
        k_ovn = {1'b1, 1'b1, 32'h7FFFFFFF};
`endif

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_bit("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_outputs", {bus.cout, bus.ovf, bus.sum}, '0);
        check_bit("reset_in_ready", bus.in_ready, 1'b0);
        rst = 1'b0;

        // Carry through every bit, with exact latency
        step(1'b1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, {1'b1, 1'b0, 32'h0}, acc);
        bus.in_valid = 1'b0;
        check_bit("accept_first", acc, 1'b1);
        check_bit("latency_edge0", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        check_bit("latency_edge1", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        check_bit("latency_edge2", bus.out_valid, 1'b1);
        check("carry_all_ones", {bus.cout, bus.ovf, bus.sum}, {1'b1, 1'b0, 32'h0});
        drain();

        // Overflow and subtraction cases, back to back
        step(1'b1, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, k039, acc);
        step(1'b1, 32'd5, 32'd7, 1'b0, 1'b1, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFFFFFE}, acc);
        step(1'b1, 32'd7, 32'd5, 1'b0, 1'b1, 1'b1, 1'b1, {1'b1, 1'b0, 32'h00000002}, acc);
        step(1'b1, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFFFFFD}, acc);
        step(1'b1, 32'h80000000, 32'd1, 1'b0, 1'b1, 1'b1, 1'b1, k_ovn, acc);
        step(1'b1, 32'h00FF00FF, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 32'h100E100E}, acc);
        drain();

        // Ten beats back to back with a downstream stall in cycles 3-6
        sent = 0;
        cyc  = 0;
        while (sent < 10 && cyc < 100) begin
            step(sent < 10, $urandom, $urandom, (cyc % 2) == 1, (cyc % 3) == 0,
                 !(cyc >= 3 && cyc <= 6), 1'b0, '0, acc);
            if (acc) sent++;
            cyc++;
        end
        check_bit("stall_all_accepted", sent == 10, 1'b1);
        drain();

        // Reset with two beats in flight
        step(1'b1, 32'd100, 32'd200, 1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
        step(1'b1, 32'd300, 32'd400, 1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check_bit("flush_out_valid", bus.out_valid, 1'b0);
        check("flush_outputs", {bus.cout, bus.ovf, bus.sum}, '0);
        step(1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b1, {2'b00, 32'h23456789}, acc);
        bus.in_valid = 1'b0;
        check_bit("post_reset_accept", acc, 1'b1);
        check_bit("post_reset_edge0", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        check_bit("post_reset_edge1", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        check_bit("post_reset_edge2", bus.out_valid, 1'b1);
        drain();
        repeat (4) begin
            @(posedge clk); #1;
        end

        // Random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 1'b0, '0, acc);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
